axi_lite_ram: RTL



---
 rtl/axi_lite_ram_if.sv | 37 +++
 rtl/axi_lite_ram.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/axi_lite_ram_if.sv
// AXI4-Lite bus bundle between the address-decode bridge (master) and the
// word-organised RAM responder (slave).
interface axi_lite_ram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_lite_ram.sv
// AXI4-Lite responder in front of a 2^ADDR_WIDTH x 32-bit RAM with byte strobes;
// independent read and write FSMs, SLVERR for addresses beyond the array.
module axi_lite_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input logic           clk,
  input logic           rst,
  axi_lite_ram_if.slave axi
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_WRITE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [1:0]            r_state;
  logic [1:0]            w_state;
  logic [31:0]           rd_addr;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  unused_addr_bits;

  assign rd_idx      = rd_addr[ADDR_WIDTH+1:2];
  assign wr_idx      = wr_addr[ADDR_WIDTH+1:2];
  assign rd_in_range = (rd_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign wr_in_range = (wr_addr >> (ADDR_WIDTH + 2)) == 32'd0;

  // Byte offset bits are ignored: misaligned accesses act on the containing word.
  assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      rd_addr     <= '0;
      axi.arready <= 1'b1;
      axi.rvalid  <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi.arvalid && axi.arready) begin
            rd_addr     <= axi.araddr;
            axi.arready <= 1'b0;
            r_state     <= R_READ;
          end
        end
        R_READ: begin
          if (rd_in_range) begin
            axi.rdata <= mem[rd_idx];
            axi.rresp <= RESP_OKAY;
          end else begin
            axi.rdata <= '0;
            axi.rresp <= RESP_SLVERR;
          end
          axi.rvalid <= 1'b1;
          r_state    <= R_RESP;
        end
        R_RESP: begin
          if (axi.rvalid && axi.rready) begin
            axi.rvalid  <= 1'b0;
            axi.arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // In W_IDLE a low ready means that channel was already captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_strb     <= '0;
      axi.awready <= 1'b1;
      axi.wready  <= 1'b1;
      axi.bvalid  <= 1'b0;
      axi.bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi.awvalid && axi.awready) begin
            wr_addr     <= axi.awaddr;
            axi.awready <= 1'b0;
          end
          if (axi.wvalid && axi.wready) begin
            wr_data    <= axi.wdata;
            wr_strb    <= axi.wstrb;
            axi.wready <= 1'b0;
          end
          if ((!axi.awready || axi.awvalid) && (!axi.wready || axi.wvalid)) begin
            w_state <= W_WRITE;
          end
        end
        W_WRITE: begin
          axi.bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
          axi.bvalid <= 1'b1;
          w_state    <= W_RESP;
        end
        W_RESP: begin
          if (axi.bvalid && axi.bready) begin
            axi.bvalid  <= 1'b0;
            axi.awready <= 1'b1;
            axi.wready  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array has no reset; nonblocking update keeps a same-cycle read read-first.
  always_ff @(posedge clk) begin
    if (w_state == W_WRITE && wr_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end
endmodule
